// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer with sticky overflow and retired-result counter.
// Optional flag check (ALU_FLAG_CHECK_EN) adds flag_err and recomputes out_zero at capture.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_cout,
    input  logic             in_over,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_over,
    output logic             over_sticky,
    input  logic             clr_sticky,
`ifdef ALU_FLAG_CHECK_EN
    output logic             flag_err,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             cout;
        logic             over;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    ent_t             head_q, head_d;
    ent_t             skid_q, skid_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ent_t             in_ent;
    logic             in_fire;
    logic             out_fire;

`ifdef ALU_FLAG_CHECK_EN
    logic ferr_q, ferr_d;
    logic zero_calc;

    assign zero_calc = (in_result == '0);
    assign flag_err  = ferr_q;
`endif

    // Handshake outputs depend only on the state register.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_result  = head_q.result;
    assign out_zero    = head_q.zero;
    assign out_cout    = head_q.cout;
    assign out_over    = head_q.over;
    assign over_sticky = sticky_q;
    assign xfer_cnt    = cnt_q;

    always_comb begin
        in_ent.result = in_result;
`ifdef ALU_FLAG_CHECK_EN
        in_ent.zero   = zero_calc;
`else
        in_ent.zero   = in_zero;
`endif
        in_ent.cout   = in_cout;
        in_ent.over   = in_over;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    head_d  = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d = in_ent;
                end else if (in_fire) begin
                    skid_d  = in_ent;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Set has priority over a same-cycle clear.
    always_comb begin
        sticky_d = (sticky_q & ~clr_sticky) | (in_fire & in_over);
        cnt_d    = out_fire ? (cnt_q + CNT_ONE) : cnt_q;
    end

`ifdef ALU_FLAG_CHECK_EN
    always_comb begin
        ferr_d = (ferr_q & ~clr_sticky) | (in_fire & (in_zero != zero_calc));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end
`else
    logic unused_zero;
    assign unused_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage placed directly downstream of the 32-bit ALU slices.
- Captures the ALU result word and its flags (zero, cout, over) into a 2-entry skid buffer with valid/ready handshake on both sides.
- Decouples the combinational ALU from the next consumer (writeback / branch unit).
- Also provides a sticky overflow flag and a retired-result counter.

Parameters:
- WIDTH, 32, data width of the result word.
- CNT_W, 16, width of the retired-result counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a valid ALU result this cycle.
- in_ready  output  1  stage can accept; driven from state register only.
- in_result  input  WIDTH  ALU result word.
- in_zero  input  1  ALU zero flag.
- in_cout  input  1  ALU carry-out.
- in_over  input  1  ALU overflow.
- out_valid  output  1  out_* fields hold a valid entry.
- out_ready  input  1  downstream accepts the head entry.
- out_result  output  WIDTH  head entry result.
- out_zero  output  1  head entry zero flag.
- out_cout  output  1  head entry carry-out.
- out_over  output  1  head entry overflow.
- over_sticky  output  1  set by any accepted entry with in_over=1.
- clr_sticky  input  1  synchronous clear of over_sticky.
- xfer_cnt  output  CNT_W  count of entries delivered (out_fire).

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: head register (drives out_*) and skid register. State register: EMPTY, ONE, TWO.
- Reset (async, while rst=1):
  - state=EMPTY, out_valid=0, out_result=0, out_zero/out_cout/out_over=0.
  - Skid register=0, over_sticky=0, xfer_cnt=0.
  - in_ready=1 (follows EMPTY).
- in_ready = (state != TWO). No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). out_* come directly from the head register; no combinational path from in_* to out_*.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle), when the head is empty or is draining in the same cycle.
- Transitions:
  - EMPTY: in_fire -> head<=in, ONE; else stay.
  - ONE: in_fire & out_fire -> head<=in, stay ONE. in_fire only -> skid<=in, TWO. out_fire only -> EMPTY. Neither -> hold.
  - TWO: in_ready=0, so in_valid is ignored. out_fire -> head<=skid, ONE. Else hold both.
- Ordering: strict FIFO; no entry dropped or duplicated. Head and skid contents are stable while not popped.
- Flags travel with their result word; no flag recomputation in base build.
- over_sticky:
  - Set on in_fire & in_over.
  - Cleared by clr_sticky.
  - Simultaneous set and clear -> set wins (result 1).
- xfer_cnt: +1 on each out_fire; wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all buffered entries discarded immediately; no out_fire counted.
- in_* values are don't-care when in_valid=0. out_ready is don't-care when out_valid=0.

Optional Feature:
- Macro: ALU_FLAG_CHECK_EN.
- Defined:
  - Adds output flag_err (1 bit, reset 0).
  - On in_fire, flag_err is set sticky if in_zero != (in_result == 0).
  - Cleared by clr_sticky; set wins on a same-cycle conflict.
  - The head entry's out_zero is replaced with the recomputed value (in_result == 0) at capture.
- Undefined: no flag_err port; in_zero is passed through unchanged.

Test Plan:
- Reset then single push: rst pulse, in_valid=1, in_result=32'h0000_00F0, in_zero=0, out_ready=1 -> after 1 edge out_valid=1, out_result=32'h0000_00F0; next edge out_valid=0, xfer_cnt=1.
- Backpressure fill: out_ready=0, push 32'h1 then 32'h2 -> state TWO, in_ready=0; a 3rd push of 32'h3 is ignored. Then out_ready=1 -> outputs 32'h1, then 32'h2, never 32'h3.
- Streaming: in_valid=1, out_ready=1 held for 100 cycles with incrementing data -> one result per cycle, in_ready stays 1, xfer_cnt=100, order preserved.
- Sticky overflow: push in_over=1 -> over_sticky=1. Assert clr_sticky on the same cycle as another in_over=1 push -> over_sticky stays 1. clr_sticky alone -> 0.
- Counter wrap with CNT_W=4: 17 out_fire events -> xfer_cnt=1.
- Async reset mid-operation: state TWO, assert rst between edges -> out_valid=0 and in_ready=1 immediately, before the next edge. With ALU_FLAG_CHECK_EN, pushing in_result=0, in_zero=0 -> flag_err=1 and out_zero=1.
